// File: rtl/irom_boot_loader_if.sv
// Host byte link and IROM write port of the boot loader, bundled so the
// loader and its surroundings share one declaration.
interface irom_boot_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  // Byte link: a byte moves on every clock edge where rx_valid && rx_ready.
  // The source holds rx_data while rx_valid is high and rx_ready is low.
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  irom_we;
  logic [ADDR_WIDTH-1:0] irom_addr;
  logic [31:0]           irom_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, irom_we, irom_addr, irom_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, irom_we, irom_addr, irom_wdata
  );
endinterface

// File: rtl/irom_boot_loader.sv
// Receives a framed program image over the byte link, packs it into 32-bit
// little-endian IROM words and releases the CPU once the checksum verifies.
module irom_boot_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  irom_boot_loader_if.slave  bus,
  output logic               cpu_rst_n,
  output logic               load_done,
  output logic               load_err,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [15:0]           cnt_q;
  logic [1:0]            byte_idx_q;
  logic [7:0]            csum_q;
  logic [23:0]           word_q;
  logic                  rx_ready_q, rx_ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  cpu_rst_q, cpu_rst_d;

  logic                  accept;
  logic [15:0]           frame_cnt;
  logic [16:0]           words_done;
  logic                  last_word;

  assign accept     = bus.rx_valid && rx_ready_q;
  assign frame_cnt  = {bus.rx_data, cnt_q[7:0]};
  // addr_q still holds the index of the word being completed here.
  assign words_done = 17'(addr_q) + 17'd1;
  assign last_word  = (words_done == {1'b0, cnt_q});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: the FSM only advances on an accepted byte
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        IDLE: if (bus.rx_data == MAGIC) state_d = LEN0;
        LEN0: state_d = LEN1;
        LEN1: begin
          if ({1'b0, frame_cnt} > MAX_WORDS) state_d = ERR;
          else if (frame_cnt == 16'd0)       state_d = CSUM;
          else                               state_d = DATA;
        end
        DATA: if (byte_idx_q == 2'd3 && last_word) state_d = CSUM;
        CSUM: state_d = (bus.rx_data == csum_q) ? DONE : ERR;
        DONE: state_d = DONE;
        ERR:  if (bus.rx_data == MAGIC) state_d = LEN0;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: status flags follow the state being entered
  always_comb begin
    rx_ready_d = (state_d != DONE);
    done_d     = (state_d == DONE);
    cpu_rst_d  = (state_d == DONE);
    err_d      = (state_d == ERR);
    we_d       = accept && (state_q == DATA) && (byte_idx_q == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready_q <= 1'b0;
      done_q     <= 1'b0;
      cpu_rst_q  <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready_d;
      done_q     <= done_d;
      cpu_rst_q  <= cpu_rst_d;
      err_q      <= err_d;
      we_q       <= we_d;
    end
  end

  // Datapath: count capture, byte packing, checksum and word address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      if (accept && state_q == LEN0) cnt_q[7:0] <= bus.rx_data;
      if (accept && state_q == LEN1) begin
        cnt_q[15:8] <= bus.rx_data;
        byte_idx_q  <= '0;
        csum_q      <= '0;
        addr_q      <= '0;
      end
      if (accept && state_q == DATA) begin
        csum_q     <= csum_q ^ bus.rx_data;
        byte_idx_q <= byte_idx_q + 2'd1;
        case (byte_idx_q)
          2'd0:    word_q[7:0]   <= bus.rx_data;
          2'd1:    word_q[15:8]  <= bus.rx_data;
          2'd2:    word_q[23:16] <= bus.rx_data;
          default: wdata_q       <= {bus.rx_data, word_q};
        endcase
      end
      // Address steps after each pulse except the last, so it ends at CNT-1.
      if (we_q && state_q == DATA) addr_q <= addr_q + 1'b1;
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.irom_we    = we_q;
  assign bus.irom_addr  = addr_q;
  assign bus.irom_wdata = wdata_q;
  assign cpu_rst_n      = cpu_rst_q;
  assign load_done      = done_q;
  assign load_err       = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_irom_boot_loader.sv
// Bench for irom_boot_loader: a frame-level reference model predicts every
// write pulse and status flag, and a per-cycle compare process checks them.
module tb_irom_boot_loader;

  localparam int         AW        = 10;
  localparam int         MAX_WORDS = 1 << AW;
  localparam logic [7:0] MAGIC     = 8'hA5;

  // Clock/reset block
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  irom_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();
  logic       cpu_rst_n;
  logic       load_done;
  logic       load_err;
  logic [2:0] dbg_state;

  irom_boot_loader #(.ADDR_WIDTH(AW), .MAGIC(MAGIC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cpu_rst_n (cpu_rst_n),
    .load_done (load_done),
    .load_err  (load_err),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: frame position arithmetic over the bytes seen so far
  logic [7:0]  fb[$];
  logic [31:0] exp_q[$];
  bit          started  = 0;
  bit          in_frame = 0;
  bit          exp_done = 0;
  bit          exp_err  = 0;
  int          m_cnt    = 0;
  int          exp_we_cyc = -1;
  logic [31:0] exp_addr = '0;
  int          rel_cyc  = 0;
  int          model_we_cnt = 0;

  // Observations
  logic [31:0] mem [MAX_WORDS];
  int          we_cnt = 0;

  task automatic model_accept(input logic [7:0] b);
    int n;
    logic [7:0] x;
    if (!in_frame) begin
      if (b == MAGIC) begin
        in_frame = 1;
        fb.delete();
        exp_err  = 0;
      end
    end else begin
      fb.push_back(b);
      n = fb.size();
      if (n == 2) begin
        m_cnt = {fb[1], fb[0]};
        if (m_cnt > MAX_WORDS) begin
          in_frame = 0;
          exp_err  = 1;
        end
      end else if (n > 2) begin
        if (n - 2 <= 4 * m_cnt) begin
          if ((n - 2) % 4 == 0) begin
            exp_we_cyc = cyc;
            exp_addr   = (n - 2) / 4 - 1;
            exp_q.delete();
            exp_q.push_back({fb[n-1], fb[n-2], fb[n-3], fb[n-4]});
            model_we_cnt++;
          end
        end else begin
          x = 8'h00;
          for (int i = 2; i < n - 1; i++) x = x ^ fb[i];
          in_frame = 0;
          if (b == x) exp_done = 1;
          else        exp_err  = 1;
        end
      end
    end
  endtask

  // Compare process: every cycle, outputs against model
  initial forever begin
    @(negedge clk);
    if (started) begin
      if (!rst_n) begin
        chk("rst_rx_ready",   {31'd0, bus.rx_ready}, 32'd0);
        chk("rst_irom_we",    {31'd0, bus.irom_we},  32'd0);
        chk("rst_irom_addr",  32'(bus.irom_addr),    32'd0);
        chk("rst_irom_wdata", bus.irom_wdata,        32'd0);
        chk("rst_cpu_rst_n",  {31'd0, cpu_rst_n},    32'd0);
        chk("rst_load_done",  {31'd0, load_done},    32'd0);
        chk("rst_load_err",   {31'd0, load_err},     32'd0);
      end else begin
        bit exp_we;
        exp_we = (cyc == exp_we_cyc);
        chk("irom_we", {31'd0, bus.irom_we}, {31'd0, exp_we});
        if (exp_we) begin
          chk("irom_addr",  32'(bus.irom_addr), exp_addr);
          chk("irom_wdata", bus.irom_wdata, exp_q[0]);
        end
        if (bus.irom_we) begin
          mem[bus.irom_addr] = bus.irom_wdata;
          we_cnt++;
        end
        chk("rx_ready",  {31'd0, bus.rx_ready}, {31'd0, (cyc > rel_cyc) && !exp_done});
        chk("load_done", {31'd0, load_done},    {31'd0, exp_done});
        chk("cpu_rst_n", {31'd0, cpu_rst_n},    {31'd0, exp_done});
        chk("load_err",  {31'd0, load_err},     {31'd0, exp_err});
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    #1;
    chk("async_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    started    = 1;
    in_frame   = 0;
    exp_done   = 0;
    exp_err    = 0;
    exp_we_cyc = -1;
    fb.delete();
    we_cnt       = 0;
    model_we_cnt = 0;
    for (int i = 0; i < MAX_WORDS; i++) mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    #2;
    rst_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    guard = 0;
    while (!bus.rx_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.rx_ready) begin
      total++;
      bad++;
      $display("FAIL rx_ready_timeout: byte %h not accepted within 20 cycles", b);
      bus.rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    model_accept(b);
  endtask

  logic [7:0]  frame_q[$];
  logic [31:0] words_q[$];

  task automatic send_frame(input int maxgap);
    int gap;
    foreach (frame_q[i]) begin
      gap = 0;
      if (maxgap > 0 && $urandom_range(0, 2) == 0) gap = $urandom_range(1, maxgap);
      send_byte(frame_q[i], gap);
    end
  endtask

  task automatic build_frame(input int cnt, input bit corrupt);
    logic [7:0]  x;
    logic [15:0] c16;
    logic [31:0] w;
    x   = 8'h00;
    c16 = 16'(cnt);
    frame_q.delete();
    words_q.delete();
    frame_q.push_back(MAGIC);
    frame_q.push_back(c16[7:0]);
    frame_q.push_back(c16[15:8]);
    for (int k = 0; k < cnt; k++) begin
      w = $urandom;
      if ($urandom_range(0, 7) == 0) w[15:8] = MAGIC;
      words_q.push_back(w);
      for (int b = 0; b < 4; b++) begin
        frame_q.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    frame_q.push_back(corrupt ? ~x : x);
  endtask

  task automatic load_good_frame();
    // Payload XOR: 13 ^ 93 ^ 10 = 90
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_good_image();
    chk("lit_mem0", mem[0], 32'h0000_0013);
    chk("lit_mem1", mem[1], 32'h0010_0093);
    chk("lit_done", {31'd0, load_done}, 32'd1);
    chk("lit_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #1 rst_n = 1'b0;
    do_reset();

    // Good frame, back to back
    load_good_frame();
    send_frame(0);
    settle();
    chk_good_image();
    chk("lit_we_cnt", 32'(we_cnt), 32'd2);
    chk("lit_ready_done", {31'd0, bus.rx_ready}, 32'd0);
    repeat (3) @(negedge clk);

    // Bad checksum, then recovery with the good frame
    do_reset();
    load_good_frame();
    frame_q[11] = 8'h81;
    send_frame(0);
    settle();
    chk("lit_err", {31'd0, load_err}, 32'd1);
    chk("lit_err_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    send_byte(8'h37, 0);
    load_good_frame();
    send_frame(0);
    settle();
    chk_good_image();
    chk("lit_err_cleared", {31'd0, load_err}, 32'd0);

    // Oversize count, then zero-length frames
    do_reset();
    frame_q = '{8'hA5, 8'h01, 8'h04};
    send_frame(0);
    settle();
    chk("lit_oversize_err", {31'd0, load_err}, 32'd1);
    frame_q = '{8'h11, 8'h22, 8'hA5, 8'h00, 8'h00, 8'h01};
    send_frame(0);
    settle();
    chk("lit_zero_bad_err", {31'd0, load_err}, 32'd1);
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    settle();
    chk("lit_zero_done", {31'd0, load_done}, 32'd1);
    chk("lit_zero_we_cnt", 32'(we_cnt), 32'd0);

    // Leading garbage and valid gaps
    do_reset();
    frame_q = '{8'h12, 8'h34, 8'h56};
    send_frame(0);
    load_good_frame();
    send_frame(5);
    settle();
    chk_good_image();
    chk("lit_gap_we_cnt", 32'(we_cnt), 32'd2);

    // Mid-load reset after six payload bytes
    do_reset();
    load_good_frame();
    for (int i = 0; i < 9; i++) send_byte(frame_q[i], 0);
    do_reset();
    send_frame(0);
    settle();
    chk_good_image();
    chk("lit_reload_we_cnt", 32'(we_cnt), 32'd2);

    // Randomized frames, optionally preceded by a corrupted one
    for (int it = 0; it < 10; it++) begin
      do_reset();
      for (int g = 0; g < $urandom_range(0, 3); g++) send_byte(8'($urandom_range(0, 8'hA4)), 0);
      if ($urandom_range(0, 1) == 1) begin
        build_frame($urandom_range(1, 5), 1);
        send_frame(4);
        settle();
        chk("rand_err", {31'd0, load_err}, 32'd1);
      end
      build_frame($urandom_range(1, 8), 0);
      send_frame(($urandom_range(0, 1) == 1) ? 5 : 0);
      settle();
      chk("rand_done", {31'd0, load_done}, 32'd1);
      chk("rand_we_cnt", 32'(we_cnt), 32'(model_we_cnt));
      foreach (words_q[k]) chk("rand_mem", mem[k], words_q[k]);
    end

    // Largest legal image
    do_reset();
    build_frame(MAX_WORDS, 0);
    send_frame(0);
    settle();
    chk("max_done", {31'd0, load_done}, 32'd1);
    chk("max_we_cnt", 32'(we_cnt), 32'(MAX_WORDS));
    chk("max_mem_last", mem[MAX_WORDS-1], words_q[MAX_WORDS-1]);
    chk("max_mem_first", mem[0], words_q[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
